// File: rtl/activation_lut_loader.sv
// Run-time loader for the 16-entry activation LUT: streams signed samples in over
// valid/ready and serves the interpolator's base/next read pair combinationally.
module activation_lut_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load__start,
  input  logic                  load__abort,
  input  logic                  wr__valid,
  output logic                  wr__ready,
  input  logic [DATA_WIDTH-1:0] wr__data,
  output logic                  busy,
  output logic                  done,
  output logic                  table__valid,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] base,
  output logic [DATA_WIDTH-1:0] next__data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [ADDR_WIDTH-1:0]         cnt_q, cnt_d;
  logic                          tv_q, tv_d;
  logic                          we;
  logic signed [DATA_WIDTH-1:0]  entry_q [DEPTH];
  logic [ADDR_WIDTH-1:0]         addr_nxt;

  // The interpolator's upper neighbour clamps at the last entry instead of wrapping.
  function automatic logic [ADDR_WIDTH-1:0] sat_next_addr(input logic [ADDR_WIDTH-1:0] a);
    if (a == LAST_IDX) begin
      return a;
    end
    return a + 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tv_d      = tv_q;
    we        = 1'b0;
    wr__ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load__start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          tv_d    = 1'b0;
        end
      end
      S_LOAD: begin
        wr__ready = 1'b1;
        busy      = 1'b1;
        // Abort wins over a coincident beat so a half-written sample never lands.
        if (load__abort) begin
          state_d = S_IDLE;
        end else if (wr__valid) begin
          we    = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        tv_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tv_q    <= tv_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else if (we) begin
      entry_q[cnt_q] <= wr__data;
    end
  end

  assign table__valid = tv_q;
  assign addr_nxt     = sat_next_addr(address);
  assign base         = entry_q[address];
  assign next__data   = entry_q[addr_nxt];

endmodule

// File: tb/tb_activation_lut_loader.sv
// Bench for activation_lut_loader: directed scenarios plus randomized loads against
// an array model of the table contents.
module tb_activation_lut_loader;

  logic       clk;
  logic       rst;
  logic       load__start;
  logic       load__abort;
  logic       wr__valid;
  logic       wr__ready;
  logic [7:0] wr__data;
  logic       busy;
  logic       done;
  logic       table__valid;
  logic [3:0] address;
  logic [7:0] base;
  logic [7:0] next__data;

  int checks;
  int failures;
  logic [7:0] ref_tbl [16];

  activation_lut_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .load__start(load__start), .load__abort(load__abort),
    .wr__valid(wr__valid), .wr__ready(wr__ready), .wr__data(wr__data),
    .busy(busy), .done(done), .table__valid(table__valid),
    .address(address), .base(base), .next__data(next__data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    load__start = 1'b1;
    tick();
    load__start = 1'b0;
  endtask

  function automatic logic [7:0] ramp(input int i);
    return 8'(i * 8 - 64);
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, wr__ready, done, table__valid} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000", {busy, wr__ready, done, table__valid});
    end
    rst = 1'b1;
    tick();
    do_start();
    for (int i = 0; i < 7; i++) begin
      wr__valid = 1'b1;
      wr__data  = 8'(i + 1);
      tick();
    end
    wr__valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_preload_busy got=%b want=1", busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, table__valid, wr__ready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_midload_flags got=%b want=000", {busy, table__valid, wr__ready});
    end
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      checks++;
      if (base !== 8'd0 || next__data !== 8'd0) begin
        failures++;
        $display("FAIL reset_entry a=%0d base=%0d next=%0d want=0/0", a, base, next__data);
      end
    end
    for (int a = 0; a < 16; a++) ref_tbl[a] = 8'd0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_full_load();
    do_start();
    for (int i = 0; i < 16; i++) begin
      address   = 4'(i);
      wr__valid = 1'b1;
      wr__data  = ramp(i);
      #1;
      checks++;
      if (wr__ready !== 1'b1 || done !== 1'b0 || base !== ref_tbl[i]) begin
        failures++;
        $display("FAIL full_beat i=%0d ready=%b done=%b base=%0d want ready=1 done=0 base=%0d",
                 i, wr__ready, done, base, ref_tbl[i]);
      end
      tick();
      ref_tbl[i] = ramp(i);
    end
    wr__valid = 1'b0;
    checks++;
    if (done !== 1'b1 || wr__ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL full_done_pulse done=%b ready=%b busy=%b want 1/0/0", done, wr__ready, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || table__valid !== 1'b1) begin
      failures++;
      $display("FAIL full_after done=%b tv=%b want 0/1", done, table__valid);
    end
    address = 4'd3;
    #1;
    checks++;
    if ($signed(base) !== -8'sd40 || $signed(next__data) !== -8'sd32) begin
      failures++;
      $display("FAIL full_addr3 base=%0d next=%0d want -40/-32", $signed(base), $signed(next__data));
    end
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      checks++;
      if (base !== ref_tbl[a] || next__data !== ref_tbl[(a == 15) ? 15 : a + 1]) begin
        failures++;
        $display("FAIL full_table a=%0d base=%0d next=%0d", a, base, next__data);
      end
    end
  endtask

  task automatic test_saturation();
    address = 4'd15;
    #1;
    checks++;
    if ($signed(base) !== 8'sd56 || $signed(next__data) !== 8'sd56) begin
      failures++;
      $display("FAIL saturation base=%0d next=%0d want 56/56", $signed(base), $signed(next__data));
    end
  endtask

  task automatic test_backpressure();
    int beats;
    int k;
    do_start();
    for (int i = 0; i < 16; i++) begin
      wr__valid = 1'b1;
      wr__data  = 8'($urandom);
      ref_tbl[i] = wr__data;
      tick();
    end
    wr__valid = 1'b0;
    tick();
    tick();
    do_start();
    beats = 0;
    k = 0;
    while (beats < 16 && k < 100) begin
      wr__valid = (k % 3 == 0);
      wr__data  = wr__valid ? ramp(beats) : 8'hA5;
      #1;
      checks++;
      if (wr__ready !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_ready k=%0d ready=%b busy=%b want 1/1", k, wr__ready, busy);
      end
      tick();
      if (wr__valid) begin
        ref_tbl[beats] = ramp(beats);
        beats++;
      end
      k++;
    end
    wr__valid = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL bp_done got=%b want=1 beats=%0d", done, beats);
    end
    tick();
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      checks++;
      if (base !== ramp(a) || table__valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_table a=%0d base=%0d tv=%b want %0d/1", a, $signed(base), table__valid,
                 $signed(ramp(a)));
      end
    end
  endtask

  task automatic test_abort();
    do_start();
    for (int i = 0; i < 5; i++) begin
      wr__valid = 1'b1;
      wr__data  = 8'(8'h70 + i);
      tick();
      ref_tbl[i] = 8'(8'h70 + i);
    end
    wr__data    = 8'h7F;
    load__abort = 1'b1;
    tick();
    load__abort = 1'b0;
    wr__valid   = 1'b0;
    checks++;
    if ({busy, wr__ready, table__valid, done} !== 4'b0000) begin
      failures++;
      $display("FAIL abort_flags got=%b want=0000", {busy, wr__ready, table__valid, done});
    end
    for (int a = 0; a < 16; a++) begin
      address = 4'(a);
      #1;
      checks++;
      if (base !== ref_tbl[a]) begin
        failures++;
        $display("FAIL abort_table a=%0d base=%0d want=%0d", a, base, ref_tbl[a]);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle busy=%b want=0", busy);
    end
    do_start();
    for (int i = 0; i < 16; i++) begin
      wr__valid = 1'b1;
      wr__data  = 8'($urandom);
      ref_tbl[i] = wr__data;
      tick();
    end
    wr__valid = 1'b0;
    tick();
    checks++;
    if (table__valid !== 1'b1) begin
      failures++;
      $display("FAIL abort_reload_tv got=%b want=1", table__valid);
    end
  endtask

  task automatic test_stray_start();
    do_start();
    for (int i = 0; i < 16; i++) begin
      wr__valid   = 1'b1;
      wr__data    = 8'(i * 3);
      load__start = (i == 9);
      tick();
      load__start = 1'b0;
      ref_tbl[i] = 8'(i * 3);
      if (i < 15) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          failures++;
          $display("FAIL stray_mid i=%0d busy=%b done=%b want 1/0", i, busy, done);
        end
      end
    end
    wr__valid = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL stray_done got=%b want=1", done);
    end
    tick();
    address = 4'd9;
    #1;
    checks++;
    if (table__valid !== 1'b1 || base !== 8'd27 || next__data !== 8'd30) begin
      failures++;
      $display("FAIL stray_table tv=%b base=%0d next=%0d want 1/27/30", table__valid, base, next__data);
    end
  endtask

  task automatic test_random_loads();
    for (int n = 0; n < 4; n++) begin
      int beats;
      int abort_at;
      int k;
      logic aborted;
      abort_at = (n == 1) ? int'($urandom_range(1, 14)) : -1;
      aborted  = 1'b0;
      beats = 0;
      k = 0;
      do_start();
      while (beats < 16 && !aborted && k < 200) begin
        wr__valid = 1'($urandom_range(0, 1));
        wr__data  = 8'($urandom);
        load__abort = (beats == abort_at) && wr__valid;
        tick();
        if (load__abort) begin
          aborted = 1'b1;
        end else if (wr__valid) begin
          ref_tbl[beats] = wr__data;
          beats++;
        end
        load__abort = 1'b0;
        k++;
      end
      wr__valid = 1'b0;
      tick();
      checks++;
      if (table__valid !== !aborted || busy !== 1'b0) begin
        failures++;
        $display("FAIL rand_end n=%0d tv=%b busy=%b want tv=%b busy=0", n, table__valid, busy, !aborted);
      end
      for (int a = 0; a < 16; a++) begin
        address = 4'(a);
        #1;
        checks++;
        if (base !== ref_tbl[a] || next__data !== ref_tbl[(a == 15) ? 15 : a + 1]) begin
          failures++;
          $display("FAIL rand_table n=%0d a=%0d base=%0d next=%0d", n, a, base, next__data);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    load__start = 1'b0;
    load__abort = 1'b0;
    wr__valid = 1'b0;
    wr__data = 8'd0;
    address = 4'd0;
    for (int a = 0; a < 16; a++) ref_tbl[a] = 8'd0;
    test_reset();
    test_full_load();
    test_saturation();
    test_backpressure();
    test_abort();
    test_stray_start();
    test_random_loads();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
